// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared types and defaults for the FIFO reader slice.
//   reader_state_t      : burst controller state encoding (IDLE, RUN, FLUSH)
//   SKID_DEPTH_DEFAULT  : default output buffer depth (2 sustains full rate)
//   LEN_W_DEFAULT       : default width of burst length and counters
// The data width comes from the common `WIDTH define (32 unless overridden).
`ifndef WIDTH
`define WIDTH 32
`endif

package fifo_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } reader_state_t;

    localparam int SKID_DEPTH_DEFAULT = 2;
    localparam int LEN_W_DEFAULT      = 16;

endpackage

// File: rtl/fifo_reader_skid.sv
// skid_buffer: small circular buffer holding words returned by the FIFO until
// the downstream stream accepts them. First-word fall-through on head.
// Ports:
//   clk, reset      : clock and synchronous active-high reset
//   flush           : drop all contents this cycle (wins over push/pop)
//   push, push_data : write one word
//   pop             : remove the head word (ignored when empty)
//   head            : current head word
//   count           : occupancy, 0..DEPTH
//   empty, full     : occupancy flags
// Push and pop may coincide at any occupancy; the caller's credit scheme
// keeps push-when-full from happening.
module skid_buffer
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Pointer advance with wrap at DEPTH-1 (DEPTH need not be a power of two).
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == LAST_PTR) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1'b1);
        end
        return nxt;
    endfunction

    assign empty = (count_r == {CNT_W{1'b0}});
    assign full  = (count_r == CNT_W'(DEPTH));
    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

    // A full buffer still takes a push when it pops in the same cycle.
    assign do_pop_s  = pop & ~flush & ~empty;
    assign do_push_s = push & ~flush & (~full | do_pop_s);

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= ptr_next(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= ptr_next(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage write; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: consumer-side controller for the synchronous FIFO. Pops an
// exact burst of `len` words per `start`, absorbs the FIFO's one-cycle read
// latency and re-presents the words on a valid/ready stream.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   start, len              : burst command (len sampled with start)
//   busy, done              : burst in progress / one-cycle completion pulse
//   fifo_ready, fifo_read   : FIFO non-empty / pop strobe (combinational)
//   fifo_valid, fifo_data   : FIFO read response, one cycle after a pop
//   m_valid, m_ready        : output stream handshake
//   m_data, m_last          : output word and end-of-burst marker
// Optional: define FIFO_READER_ABORT_EN to add `abort` (input) and `aborted`
// (output). Without it a burst always runs to completion.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int WIDTH      = `WIDTH,
    parameter int SKID_DEPTH = SKID_DEPTH_DEFAULT,
    parameter int LEN_W      = LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    input  logic             fifo_ready,
    output logic             fifo_read,
    input  logic             fifo_valid,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last
`ifdef FIFO_READER_ABORT_EN
    ,
    input  logic             abort,
    output logic             aborted
`endif
);

    localparam int CNT_W = $clog2(SKID_DEPTH + 1);

    reader_state_t    state_r;
    reader_state_t    state_nxt_s;
    logic [LEN_W-1:0] len_q_r;
    logic [LEN_W-1:0] rcv_cnt_r;
    logic [LEN_W-1:0] out_cnt_r;
    logic             inflight_r;
    logic             done_r;
    logic             busy_r;

    logic             abort_s;
    logic             accept_s;
    logic             hs_s;
    logic             last_hs_s;
    logic             start_ok_s;
    logic             done_nxt_s;
    logic             read_s;
    logic [LEN_W:0]   rcv_sum_s;
    logic [LEN_W:0]   rcv_pend_s;
    logic [CNT_W:0]   cred_used_s;
    logic [CNT_W:0]   cred_lim_s;
    logic [CNT_W-1:0] skid_count_s;
    logic             skid_empty_s;
    logic             skid_full_s;
    logic [WIDTH-1:0] skid_head_s;

`ifdef FIFO_READER_ABORT_EN
    logic aborted_r;
    assign abort_s = abort & busy_r;
    assign aborted = aborted_r;
`else
    assign abort_s = 1'b0;
`endif

    assign hs_s       = m_valid & m_ready;
    assign last_hs_s  = hs_s & m_last;
    assign start_ok_s = start & (state_r == IDLE);

    // Only a response to our own outstanding pop counts; a missing response
    // means the FIFO dropped the pop and the word will be requested again.
    assign accept_s   = inflight_r & fifo_valid & ~abort_s;

    // Counter sums one bit wider so len = 2^LEN_W - 1 cannot wrap.
    assign rcv_sum_s  = {1'b0, rcv_cnt_r} + (LEN_W+1)'(accept_s);
    assign rcv_pend_s = {1'b0, rcv_cnt_r} + (LEN_W+1)'(inflight_r);

    // Credit: buffered words plus the pop in flight must leave room for one
    // more; the limit grows by one when the head leaves this cycle.
    assign cred_used_s = {1'b0, skid_count_s} + (CNT_W+1)'(inflight_r);
    assign cred_lim_s  = (CNT_W+1)'(SKID_DEPTH) + (CNT_W+1)'(hs_s);

    // Pop request: running, FIFO non-empty, burst not yet covered, credit left.
    always_comb begin
        read_s = 1'b0;
        if ((state_r == RUN) && fifo_ready && !abort_s &&
            (rcv_pend_s < {1'b0, len_q_r}) &&
            (cred_used_s < cred_lim_s) && !(skid_full_s && !hs_s)) begin
            read_s = 1'b1;
        end else begin
            read_s = 1'b0;
        end
    end

    // Next-state and done-pulse decode.
    always_comb begin
        state_nxt_s = state_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && (len != {LEN_W{1'b0}})) begin
                    state_nxt_s = RUN;
                end else if (start) begin
                    done_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (abort_s) begin
                    state_nxt_s = IDLE;
                    done_nxt_s  = 1'b1;
                end else if (rcv_sum_s == {1'b0, len_q_r}) begin
                    state_nxt_s = FLUSH;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            FLUSH: begin
                if (abort_s || last_hs_s) begin
                    state_nxt_s = IDLE;
                    done_nxt_s  = 1'b1;
                end else begin
                    state_nxt_s = FLUSH;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Controller state, burst counters and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            len_q_r    <= {LEN_W{1'b0}};
            rcv_cnt_r  <= {LEN_W{1'b0}};
            out_cnt_r  <= {LEN_W{1'b0}};
            inflight_r <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            busy_r     <= (state_nxt_s != IDLE);
            done_r     <= done_nxt_s;
            inflight_r <= read_s;
            if (start_ok_s) begin
                len_q_r   <= len;
                rcv_cnt_r <= {LEN_W{1'b0}};
                out_cnt_r <= {LEN_W{1'b0}};
            end else if (abort_s) begin
                len_q_r   <= len_q_r;
                rcv_cnt_r <= {LEN_W{1'b0}};
                out_cnt_r <= {LEN_W{1'b0}};
            end else begin
                len_q_r   <= len_q_r;
                rcv_cnt_r <= rcv_sum_s[LEN_W-1:0];
                out_cnt_r <= out_cnt_r + LEN_W'(hs_s);
            end
        end
    end

`ifdef FIFO_READER_ABORT_EN
    // Flags the done pulse that follows an abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            aborted_r <= 1'b0;
        end else begin
            aborted_r <= abort_s;
        end
    end
`endif

    skid_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort_s),
        .push      (accept_s),
        .push_data (fifo_data),
        .pop       (hs_s),
        .head      (skid_head_s),
        .count     (skid_count_s),
        .empty     (skid_empty_s),
        .full      (skid_full_s)
    );

    assign fifo_read = read_s;
    assign busy      = busy_r;
    assign done      = done_r;
    assign m_valid   = ~skid_empty_s;
    // Zero while empty so the idle/reset value of m_data is defined.
    assign m_data    = skid_empty_s ? {WIDTH{1'b0}} : skid_head_s;
    assign m_last    = m_valid & (out_cnt_r == (len_q_r - LEN_W'(1'b1)));

endmodule

// File: tb/tb_fifo_reader.sv
`timescale 1ns/1ps
module tb_fifo_reader;

    localparam int W     = 32;
    localparam int LEN_W = 16;
    localparam int DEPTH = 2;

    logic             clk;
    logic             reset;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             fifo_ready;
    logic             fifo_read;
    logic             fifo_valid;
    logic [W-1:0]     fifo_data;
    logic             m_valid;
    logic             m_ready;
    logic [W-1:0]     m_data;
    logic             m_last;
`ifdef FIFO_READER_ABORT_EN
    logic             abort;
    logic             aborted;
`endif

    fifo_reader #(
        .WIDTH      (W),
        .SKID_DEPTH (DEPTH),
        .LEN_W      (LEN_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .fifo_ready (fifo_ready),
        .fifo_read  (fifo_read),
        .fifo_valid (fifo_valid),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
`ifdef FIFO_READER_ABORT_EN
        ,
        .abort      (abort),
        .aborted    (aborted)
`endif
    );

    // Scoreboard: {last, data} expected on each output handshake.
    logic [W:0]   exp_q[$];
    // Behavioural FIFO contents and the current burst's words.
    logic [W-1:0] fq[$];
    logic [W-1:0] bw[$];

    int pass_cnt, total_cnt;
    int done_cnt, busy_cnt, read_cnt, hs_cnt, ret_cnt;
    int rd_not_ready_cnt, drop_cnt, max_occ;
    int ready_mode, pat;
    bit drop_next, drop_rand;
    logic model_rd, model_rdy;
    logic prev_stall;
    logic [W-1:0] prev_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, passed=%0d total=%0d", pass_cnt, total_cnt);
        $fatal(1);
    end

    function automatic void check(string name, longint act, longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_counts();
        done_cnt = 0; busy_cnt = 0; read_cnt = 0; hs_cnt = 0; ret_cnt = 0;
        rd_not_ready_cnt = 0; drop_cnt = 0; max_occ = 0;
    endtask

    task automatic push_fifo(input logic [W-1:0] w);
        fq.push_back(w);
        fifo_ready = 1'b1;
    endtask

    // Reference: the burst returns the listed words in order, last on the final one.
    task automatic expect_bw();
        for (int i = 0; i < bw.size(); i++)
            exp_q.push_back({(i == bw.size() - 1) ? 1'b1 : 1'b0, bw[i]});
    endtask

    task automatic pulse_start(input int l);
        start = 1'b1;
        len   = LEN_W'(l);
        tick();
        start = 1'b0;
        len   = LEN_W'($urandom);
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        int i;
        d0 = done_cnt;
        i  = 0;
        while (done_cnt == d0 && i < budget) begin
            tick();
            i++;
        end
        check({name, "_done_seen"}, (done_cnt != d0) ? 1 : 0, 1);
        repeat (3) tick();
    endtask

    task automatic burst_checks(input string name, input int n);
        check({name, "_outputs"}, hs_cnt, n);
        check({name, "_scoreboard_empty"}, exp_q.size(), 0);
        check({name, "_done_once"}, done_cnt, 1);
        check({name, "_reads"}, read_cnt, n + drop_cnt);
        check({name, "_read_not_ready"}, rd_not_ready_cnt, 0);
        check({name, "_credit_ok"}, (max_occ <= DEPTH) ? 1 : 0, 1);
    endtask

    // FIFO model: answers a pop one cycle later; may drop a pop on request.
    initial begin
        fifo_valid = 1'b0; fifo_data = '0; fifo_ready = 1'b0; m_ready = 1'b1; pat = 0;
        forever begin
            @(posedge clk);
            model_rd  = fifo_read;
            model_rdy = fifo_ready;
            #1;
            fifo_valid = 1'b0;
            if (model_rd) begin
                if (!model_rdy || fq.size() == 0) begin
                    rd_not_ready_cnt++;
                end else if (drop_next || (drop_rand && $urandom_range(0, 5) == 0)) begin
                    drop_next = 1'b0;
                    drop_cnt++;
                end else begin
                    fifo_valid = 1'b1;
                    fifo_data  = fq.pop_front();
                    ret_cnt++;
                end
            end
            fifo_ready = (fq.size() != 0);
            case (ready_mode)
                0: m_ready = 1'b1;
                1: begin m_ready = (pat == 0); pat = (pat + 1) % 3; end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin
        logic [W:0] e;
        int occ;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", m_valid, 1);
                    check("hold_data", m_data, prev_data);
                end
                if (m_valid && m_ready) begin
                    hs_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", m_data, 64'hDEAD_0000_0000);
                    end else begin
                        e = exp_q.pop_front();
                        check("m_data", m_data, e[W-1:0]);
                        check("m_last", m_last, e[W]);
                    end
                end
                if (done) done_cnt++;
                if (busy) busy_cnt++;
                if (fifo_read) read_cnt++;
                occ = ret_cnt - hs_cnt + (fifo_read ? 1 : 0);
                if (occ > max_occ) max_occ = occ;
                prev_stall = m_valid & ~m_ready;
                prev_data  = m_data;
            end
        end
    end

    initial begin
        pass_cnt = 0; total_cnt = 0; ready_mode = 0; drop_next = 0; drop_rand = 0;
        start = 1'b0; len = '0; reset = 1'b1;
`ifdef FIFO_READER_ABORT_EN
        abort = 1'b0;
`endif
        clear_counts();
        tick();
        tick();
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fifo_read", fifo_read, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_last", m_last, 0);
        check("rst_m_data", m_data, 0);
        tick();
        reset = 1'b0;
        tick();

        // Full-rate burst of 8 with downstream always ready.
        clear_counts(); ready_mode = 0;
        bw.delete();
        for (int i = 0; i < 8; i++) bw.push_back(W'(32'h10 + i));
        expect_bw();
        foreach (bw[i]) push_fifo(bw[i]);
        pulse_start(8);
        wait_done("t1", 100);
        burst_checks("t1", 8);
        check("t1_busy_cycles", busy_cnt, 10);

        // Back-pressure pattern 1,0,0.
        clear_counts(); ready_mode = 1; pat = 0;
        bw.delete();
        for (int i = 0; i < 4; i++) bw.push_back(W'(32'hA0 + i));
        expect_bw();
        foreach (bw[i]) push_fifo(bw[i]);
        pulse_start(4);
        wait_done("t2", 100);
        burst_checks("t2", 4);

        // FIFO starts empty; words trickle in 5 cycles apart.
        clear_counts(); ready_mode = 0;
        bw.delete();
        for (int i = 0; i < 3; i++) bw.push_back(W'(32'h300 + i));
        expect_bw();
        pulse_start(3);
        for (int i = 0; i < 3; i++) begin
            repeat (4) tick();
            if (i == 2) begin
                @(negedge clk);
                check("t3_waiting_in_run", busy, 1);
                check("t3_no_read_while_empty", fifo_read, 0);
                tick();
            end else begin
                tick();
            end
            push_fifo(bw[i]);
        end
        wait_done("t3", 100);
        burst_checks("t3", 3);

        // One dropped read response, random back-pressure.
        clear_counts(); ready_mode = 2;
        bw.delete();
        for (int i = 0; i < 5; i++) bw.push_back(W'(32'h400 + i));
        expect_bw();
        foreach (bw[i]) push_fifo(bw[i]);
        drop_next = 1'b1;
        pulse_start(5);
        wait_done("t4", 200);
        burst_checks("t4", 5);
        check("t4_drops", drop_cnt, 1);

        // Zero-length burst, then start pulsed while busy.
        clear_counts(); ready_mode = 0;
        pulse_start(0);
        @(negedge clk);
        check("t5_len0_done_next", done, 1);
        check("t5_len0_not_busy", busy, 0);
        repeat (3) tick();
        check("t5_len0_no_reads", read_cnt, 0);
        check("t5_len0_done_once", done_cnt, 1);
        clear_counts(); ready_mode = 1; pat = 0;
        bw.delete();
        for (int i = 0; i < 3; i++) bw.push_back(W'(32'hB0 + i));
        expect_bw();
        for (int i = 0; i < 6; i++) push_fifo(W'(32'hB0 + i));
        pulse_start(3);
        tick();
        pulse_start(2);
        wait_done("t5", 100);
        burst_checks("t5", 3);
        check("t5_fifo_leftover", fq.size(), 3);
        fq.delete();
        fifo_ready = 1'b0;
        tick();

        // Reset after 2 of 6 words, then a clean burst of 2.
        clear_counts(); ready_mode = 1; pat = 0;
        bw.delete();
        for (int i = 0; i < 6; i++) bw.push_back(W'(32'hC0 + i));
        expect_bw();
        foreach (bw[i]) push_fifo(bw[i]);
        pulse_start(6);
        for (int i = 0; i < 100 && hs_cnt < 2; i++) tick();
        check("t6_two_words_before_reset", hs_cnt, 2);
        reset = 1'b1;
        tick();
        @(negedge clk);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_fifo_read", fifo_read, 0);
        check("t6_rst_m_valid", m_valid, 0);
        check("t6_rst_m_last", m_last, 0);
        check("t6_rst_m_data", m_data, 0);
        exp_q.delete();
        fq.delete();
        fifo_ready = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        tick();
        clear_counts(); ready_mode = 0;
        bw.delete();
        bw.push_back(W'(32'hD0));
        bw.push_back(W'(32'hD1));
        expect_bw();
        foreach (bw[i]) push_fifo(bw[i]);
        pulse_start(2);
        wait_done("t6", 100);
        burst_checks("t6", 2);

        // Randomized bursts: random data, length, trickle, back-pressure, drops.
        for (int b = 0; b < 6; b++) begin
            int n;
            int k;
            n = $urandom_range(1, 12);
            k = $urandom_range(0, n);
            clear_counts(); ready_mode = 2; drop_rand = 1'b1;
            bw.delete();
            for (int i = 0; i < n; i++) bw.push_back(W'($urandom));
            expect_bw();
            for (int i = 0; i < k; i++) push_fifo(bw[i]);
            pulse_start(n);
            for (int i = k; i < n; i++) begin
                repeat ($urandom_range(0, 3)) tick();
                push_fifo(bw[i]);
            end
            wait_done("rnd", 400);
            drop_rand = 1'b0;
            burst_checks("rnd", n);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
